// File: rtl/goal_detector.sv
// Goal detector: watches the ball centre once per frame, flags a goal, freezes play for a
// fixed number of frames, then waits for the ball to leave both goal mouths before re-arming.
module goal_detector #(
   parameter int unsigned ballWidth   = 32,
   parameter int unsigned ballHeight  = 64,
   parameter int unsigned goalWidth   = 32,
   parameter int unsigned ourGoalX    = 603,
   parameter int unsigned oppGoalX    = 32,
   parameter int unsigned goalTopY    = 205,
   parameter int unsigned goalBottomY = 269,
   parameter int unsigned HOLD_FRAMES = 120
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        gameActive,
   input  logic        ballValid,
   input  logic [10:0] ballTopLeftX,
   input  logic [10:0] ballTopLeftY,
   output logic [1:0]  goalWasScored,
   output logic        freezeGame,
   output logic        ballResetReq
);

   typedef enum logic [1:0] {StArmed, StHold, StWaitClear} state_e;

   localparam logic [11:0] HalfW    = 12'(ballWidth / 2);
   localparam logic [11:0] HalfH    = 12'(ballHeight / 2);
   localparam logic [11:0] OppLo    = 12'(oppGoalX);
   localparam logic [11:0] OppHi    = 12'(oppGoalX + goalWidth);
   localparam logic [11:0] OurLo    = 12'(ourGoalX);
   localparam logic [11:0] OurHi    = 12'(ourGoalX + goalWidth);
   localparam logic [11:0] TopY     = 12'(goalTopY);
   localparam logic [11:0] BotY     = 12'(goalBottomY);
   localparam logic [7:0]  HoldInit = 8'(HOLD_FRAMES);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  goal_q, goal_d;
   logic        rst_req_q, rst_req_d;

   logic [11:0] cx, cy;
   logic        in_y, in_opp, in_our;

   // 12-bit sums cannot overflow from 11-bit coordinates plus half a sprite
   assign cx = {1'b0, ballTopLeftX} + HalfW;
   assign cy = {1'b0, ballTopLeftY} + HalfH;

   assign in_y   = (cy >= TopY) && (cy <= BotY);
   assign in_opp = (cx >= OppLo) && (cx < OppHi) && in_y;
   assign in_our = (cx >= OurLo) && (cx < OurHi) && in_y;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      goal_d    = 2'b00;
      rst_req_d = 1'b0;
      if (startOfFrame) begin
         case (state_q)
            StArmed: begin
               if (gameActive && ballValid && (in_opp || in_our)) begin
                  state_d = StHold;
                  cnt_d   = HoldInit;
                  goal_d  = in_opp ? 2'b01 : 2'b10;
               end
            end
            StHold: begin
               if (cnt_q == 8'd1) begin
                  state_d   = StWaitClear;
                  rst_req_d = 1'b1;
                  cnt_d     = 8'd0;
               end else if (cnt_q != 8'd0) begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            StWaitClear: begin
               if (ballValid && !in_opp && !in_our) begin
                  state_d = StArmed;
               end
            end
            default: state_d = StArmed;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= StArmed;
         cnt_q     <= 8'd0;
         goal_q    <= 2'b00;
         rst_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         goal_q    <= goal_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign goalWasScored = goal_q;
   assign ballResetReq  = rst_req_q;
   assign freezeGame    = (state_q != StArmed);

endmodule

// File: tb/tb_goal_detector.sv
// Directed bench for goal_detector with a 3-frame hold; expectations are hand-computed.
module tb_goal_detector;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic        gameActive;
   logic        ballValid;
   logic [10:0] ballTopLeftX;
   logic [10:0] ballTopLeftY;
   logic [1:0]  goalWasScored;
   logic        freezeGame;
   logic        ballResetReq;

   int unsigned passes = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;

   goal_detector #(
      .HOLD_FRAMES(3)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .gameActive   (gameActive),
      .ballValid    (ballValid),
      .ballTopLeftX (ballTopLeftX),
      .ballTopLeftY (ballTopLeftY),
      .goalWasScored(goalWasScored),
      .freezeGame   (freezeGame),
      .ballResetReq (ballResetReq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic f, input logic r);
      chk({tag, ".goal"},   {6'd0, goalWasScored}, {6'd0, g});
      chk({tag, ".freeze"}, {7'd0, freezeGame},    {7'd0, f});
      chk({tag, ".rstreq"}, {7'd0, ballResetReq},  {7'd0, r});
   endtask

   // One frame tick spanning a single active edge; returns 1 time unit after that edge
   task automatic frame();
      @(negedge clk);
      startOfFrame = 1'b1;
      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      gameActive   = 1'b1;
      ballValid    = 1'b1;
      ballTopLeftX = 11'd304;
      ballTopLeftY = 11'd208;
      #3;
      chk_out("reset_async", 2'b00, 1'b0, 1'b0);
      idle(2);
      chk_out("reset_held", 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      resetN = 1'b1;

      // cx=26 lies left of the opponent mouth
      ballTopLeftX = 11'd10;
      ballTopLeftY = 11'd205;
      frame();
      chk_out("cx26_out", 2'b00, 1'b0, 1'b0);

      // cx=64 is the exclusive right bound
      ballTopLeftX = 11'd48;
      frame();
      chk_out("cx64_out", 2'b00, 1'b0, 1'b0);

      // Ball in goal but no frame tick: nothing happens
      ballTopLeftX = 11'd20;
      idle(3);
      chk_out("no_tick", 2'b00, 1'b0, 1'b0);

      frame();
      chk_out("opp_goal", 2'b01, 1'b1, 1'b0);
      idle(1);
      chk_out("opp_pulse_end", 2'b00, 1'b1, 1'b0);
      frame();
      chk_out("hold_f1", 2'b00, 1'b1, 1'b0);
      frame();
      chk_out("hold_f2", 2'b00, 1'b1, 1'b0);
      frame();
      chk_out("hold_f3", 2'b00, 1'b1, 1'b1);
      idle(1);
      chk_out("rstreq_end", 2'b00, 1'b1, 1'b0);

      // Ball left in the goal through WAIT_CLEAR: no retrigger
      for (int i = 0; i < 5; i++) begin
         frame();
         chk_out("wait_in_goal", 2'b00, 1'b1, 1'b0);
      end
      ballTopLeftX = 11'd304;
      ballTopLeftY = 11'd208;
      frame();
      chk_out("rearm", 2'b00, 1'b0, 1'b0);

      // Our goal: cy=182 above the mouth, then cy=205 on the inclusive top bound
      ballTopLeftX = 11'd600;
      ballTopLeftY = 11'd150;
      frame();
      chk_out("our_cy182", 2'b00, 1'b0, 1'b0);
      ballTopLeftY = 11'd173;
      frame();
      chk_out("our_goal", 2'b10, 1'b1, 1'b0);
      frame();
      frame();
      frame();
      chk_out("our_hold_end", 2'b00, 1'b1, 1'b1);

      // ballValid=0 in WAIT_CLEAR keeps play frozen
      ballValid    = 1'b0;
      ballTopLeftX = 11'd304;
      ballTopLeftY = 11'd208;
      frame();
      chk_out("wait_invalid", 2'b00, 1'b1, 1'b0);
      ballValid = 1'b1;
      frame();
      chk_out("wait_valid_clear", 2'b00, 1'b0, 1'b0);

      // gameActive gates only the arming transition
      gameActive   = 1'b0;
      ballTopLeftX = 11'd20;
      ballTopLeftY = 11'd205;
      frame();
      chk_out("inactive_blocked", 2'b00, 1'b0, 1'b0);
      gameActive = 1'b1;
      frame();
      chk_out("active_goal", 2'b01, 1'b1, 1'b0);
      gameActive = 1'b0;
      frame();
      chk_out("hold_inactive", 2'b00, 1'b1, 1'b0);

      // Counter now 2: reset aborts at once
      @(negedge clk);
      resetN = 1'b0;
      #1;
      chk_out("reset_mid_hold", 2'b00, 1'b0, 1'b0);
      idle(1);
      @(negedge clk);
      resetN       = 1'b1;
      gameActive   = 1'b1;
      ballTopLeftX = 11'd304;
      ballTopLeftY = 11'd208;
      for (int i = 0; i < 4; i++) begin
         frame();
         chk_out("post_reset", 2'b00, 1'b0, 1'b0);
      end

      // First evaluation after reset acts normally
      ballTopLeftX = 11'd600;
      ballTopLeftY = 11'd173;
      frame();
      chk_out("post_reset_goal", 2'b10, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
